// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
// Program base table and FSM state encoding.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_RUN,
    S_FIN,
    S_FAULT
  } run_state_t;

  localparam int PROG_CNT = 3;

  localparam logic [9:0] PROG_BASE_0 = 10'd0;
  localparam logic [9:0] PROG_BASE_1 = 10'd25;
  localparam logic [9:0] PROG_BASE_2 = 10'd451;

  function automatic logic [9:0] prog_base(
    input logic [1:0] sel
  );
    logic [9:0] b;
    unique case (sel)
      2'd0:    b = PROG_BASE_0;
      2'd1:    b = PROG_BASE_1;
      2'd2:    b = PROG_BASE_2;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host request and core control bundle of the run controller.
// master = host + core side, slave = controller.
interface cpu_run_ctrl_if #(
  parameter int D  = 10,
  parameter int CW = 16
);

  logic          req;
  logic [1:0]    prog_sel;
  logic          core_done;
  logic [D-1:0]  core_pc;
  logic          core_reset;
  logic          core_start;
  logic [D-1:0]  boot_addr;
  logic          busy;
  logic          run_done;
  logic          timeout;
  logic          bad_sel;
  logic [CW-1:0] cycles;
  logic [D-1:0]  last_pc;

  modport master (
    output req, prog_sel,
    output core_done, core_pc,
    input  core_reset, core_start,
    input  boot_addr, busy,
    input  run_done, timeout,
    input  bad_sel, cycles,
    input  last_pc
  );

  modport slave (
    input  req, prog_sel,
    input  core_done, core_pc,
    output core_reset, core_start,
    output boot_addr, busy,
    output run_done, timeout,
    output bad_sel, cycles,
    output last_pc
  );

endinterface

// File: rtl/cpu_run_ctrl_counter.sv
// RUN cycle counter with clear, enable and watchdog compare.
// hit_o flags the cycle whose increment reaches TIMEOUT.
module run_cycle_counter #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          hit_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences one core program run per host request:
// reset, start with boot address, run with watchdog.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int D            = 10,
  parameter int CW           = 16,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int SW = $clog2(START_CYCLES + 1);

  run_state_t    state_q, state_d;
  logic [1:0]    sel_q;
  logic [SW-1:0] st_cnt_q;
  logic          bad_sel_q;
  logic [D-1:0]  last_pc_q;
  logic          accept;
  logic          in_idle;
  logic          cnt_hit;
  logic [CW-1:0] cnt;

  assign in_idle = (state_q == S_IDLE);
  assign accept  = in_idle && bus.req &&
                   (bus.prog_sel < 2'(PROG_CNT));

  run_cycle_counter #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (accept),
    .en_i  (state_q == S_RUN),
    .cnt_o (cnt),
    .hit_o (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // core_done is checked first so completion beats the watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RST;
      S_RST:   state_d = S_START;
      S_START: if (st_cnt_q == '0) state_d = S_RUN;
      S_RUN: begin
        if (bus.core_done)
          state_d = S_FIN;
        else if (cnt_hit)
          state_d = S_FAULT;
      end
      S_FIN:   state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.core_reset = 1'b0;
    bus.core_start = 1'b0;
    bus.boot_addr  = '0;
    bus.run_done   = 1'b0;
    bus.timeout    = 1'b0;
    bus.busy       = !in_idle;
    unique case (1'b1)
      state_q == S_RST: bus.core_reset = 1'b1;
      state_q == S_START: begin
        bus.core_start = 1'b1;
        bus.boot_addr  = D'(prog_base(sel_q));
      end
      state_q == S_FIN: bus.run_done = 1'b1;
      state_q == S_FAULT: begin
        bus.timeout    = 1'b1;
        bus.core_reset = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= '0;
      st_cnt_q  <= '0;
      bad_sel_q <= 1'b0;
      last_pc_q <= '0;
    end else begin
      bad_sel_q <= in_idle && bus.req &&
                   (bus.prog_sel >= 2'(PROG_CNT));
      if (accept)
        sel_q <= bus.prog_sel;
      if (state_q == S_RST)
        st_cnt_q <= SW'(START_CYCLES - 1);
      else if (state_q == S_START && st_cnt_q != '0)
        st_cnt_q <= st_cnt_q - SW'(1);
      if (state_q == S_FIN || state_q == S_FAULT)
        last_pc_q <= bus.core_pc;
    end
  end

  assign bus.bad_sel = bad_sel_q;
  assign bus.cycles  = cnt;
  assign bus.last_pc = last_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: per-cycle expected
// outputs queued with the stimulus, compared mid-cycle.
module tb_cpu_run_ctrl;

  localparam int D  = 10;
  localparam int CW = 16;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.D(D), .CW(CW)) bus();

  cpu_run_ctrl #(
    .D            (D),
    .CW           (CW),
    .START_CYCLES (2),
    .TIMEOUT      (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit            chk;
    bit            rst;
    bit            req;
    logic [1:0]    sel;
    bit            done;
    logic [D-1:0]  pc;
    bit            rstc;
    bit            st;
    logic [D-1:0]  ba;
    bit            busy;
    bit            rd;
    bit            to;
    bit            bs;
    logic [CW-1:0] cyc;
    logic [D-1:0]  lpc;
  } step_t;

  step_t sb[$];
  int total = 0;
  int bad = 0;
  int stepn = 0;
  logic [CW-1:0] e_cyc = '0;
  logic [D-1:0]  e_lpc = '0;

  function automatic logic [D-1:0] base(input logic [1:0] s);
    case (s)
      2'd1:    return 10'd25;
      2'd2:    return 10'd451;
      default: return 10'd0;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d",
             tag, stepn, o, e);
    end
  endtask

  task automatic put(input bit rst, input bit req,
                     input logic [1:0] sel, input bit done,
                     input logic [D-1:0] pc, input bit rstc,
                     input bit st, input logic [D-1:0] ba,
                     input bit busy, input bit rd,
                     input bit to, input bit bs);
    step_t s;
    s.chk = 1'b1; s.rst = rst; s.req = req;
    s.sel = sel; s.done = done; s.pc = pc;
    s.rstc = rstc; s.st = st; s.ba = ba;
    s.busy = busy; s.rd = rd; s.to = to; s.bs = bs;
    s.cyc = e_cyc; s.lpc = e_lpc;
    sb.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic bad_req();
    put(0, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // done_at/rst_at/req_at are RUN cycle numbers, 0 = never
  task automatic run(input logic [1:0] sel, input int done_at,
                     input bit stale, input int rst_at,
                     input int req_at);
    logic [D-1:0] b;
    logic [D-1:0] pc;
    b = base(sel);
    put(0, 1, sel, stale, 0, 0, 0, 0, 0, 0, 0, 0);
    e_cyc = '0;
    put(0, 0, 0, stale, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      put(0, 0, 0, stale, b, 0, 1, b, 1, 0, 0, 0);
    for (int n = 1; n <= TO; n++) begin
      pc = b + D'(n);
      e_cyc = CW'(n - 1);
      if (n == rst_at) begin
        put(1, 0, 0, 0, pc, 0, 0, 0, 1, 0, 0, 0);
        e_cyc = '0;
        e_lpc = '0;
        return;
      end
      put(0, n == req_at, 0, n == done_at, pc,
          0, 0, 0, 1, 0, 0, 0);
      e_cyc = CW'(n);
      if (n == done_at) begin
        put(0, 0, 0, 1, pc, 0, 0, 0, 1, 1, 0, 0);
        e_lpc = pc;
        return;
      end
      if (n == TO) begin
        put(0, 0, 0, 0, pc, 1, 0, 0, 1, 0, 1, 0);
        e_lpc = pc;
        return;
      end
    end
  endtask

  initial begin
    step_t s;
    bus.req = 1'b0;
    bus.prog_sel = '0;
    bus.core_done = 1'b0;
    bus.core_pc = '0;

    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sb[sb.size() - 1].chk = 1'b0;
    idle(2);
    run(2'd0, 20, 0, 0, 0);
    idle(2);
    run(2'd2, 349, 0, 0, 0);
    idle(1);
    bad_req();
    idle(1);
    run(2'd1, 30, 0, 0, 10);
    run(2'd0, 5, 0, 0, 0);
    run(2'd1, 1, 1, 0, 0);
    idle(1);
    run(2'd0, 0, 0, 0, 0);
    idle(1);
    run(2'd1, TO, 0, 0, 0);
    idle(1);
    run(2'd2, 0, 0, 51, 0);
    idle(2);
    run(2'd0, 3, 0, 0, 0);
    idle(2);

    while (sb.size() > 0) begin
      @(negedge clk);
      s = sb.pop_front();
      reset = s.rst;
      bus.req = s.req;
      bus.prog_sel = s.sel;
      bus.core_done = s.done;
      bus.core_pc = s.pc;
      if (s.chk) begin
        chk("core_reset", 32'(bus.core_reset), 32'(s.rstc));
        chk("core_start", 32'(bus.core_start), 32'(s.st));
        chk("boot_addr", 32'(bus.boot_addr), 32'(s.ba));
        chk("busy", 32'(bus.busy), 32'(s.busy));
        chk("run_done", 32'(bus.run_done), 32'(s.rd));
        chk("timeout", 32'(bus.timeout), 32'(s.to));
        chk("bad_sel", 32'(bus.bad_sel), 32'(s.bs));
        chk("cycles", 32'(bus.cycles), 32'(s.cyc));
        chk("last_pc", 32'(bus.last_pc), 32'(s.lpc));
      end
      stepn++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences the single-cycle 9-bit CPU core through one program execution per host request. It resets the core, holds `start` while presenting the selected program's boot address, then watches the core's `done` while counting execution cycles. It reports completion, cycle count and watchdog timeout back to the host or testbench. It sits between the host-side request interface and the core's `reset`/`start`/`done`/PC pins.

## Interface
Parameters:
- `D`, 10, program counter width (matches core PC)
- `CW`, 16, cycle counter width
- `START_CYCLES`, 2, cycles `core_start` is held high (≥1)
- `TIMEOUT`, 4096, maximum RUN cycles before fault (≤ 2^CW − 1)

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high; returns block to IDLE
- `req`  in  1  host run request, sampled only in IDLE
- `prog_sel`  in  2  program index; valid values 0..2
- `core_done`  in  1  core's `done` output
- `core_pc`  in  D  core's current program counter
- `core_reset`  out  1  reset to core
- `core_start`  out  1  start to core
- `boot_addr`  out  D  jump target for the core during start; `PROG_BASE[sel]`
- `busy`  out  1  high from request accept until return to IDLE
- `run_done`  out  1  one-cycle pulse on normal completion
- `timeout`  out  1  one-cycle pulse on watchdog expiry
- `bad_sel`  out  1  one-cycle pulse when `req` arrives with `prog_sel` = 3
- `cycles`  out  CW  RUN cycle count of the last run, held until next accept
- `last_pc`  out  D  `core_pc` captured on completion or timeout

## Operation
- States: IDLE, RST, START, RUN, FIN, FAULT.
- IDLE: `busy` = 0. `req` with `prog_sel` ≤ 2 latches `sel`, clears `cycles`, and goes to RST. `req` with `prog_sel` = 3 pulses `bad_sel` and stays in IDLE.
- RST: `core_reset` = 1 for exactly one cycle, then START.
- START: `core_start` = 1 and `boot_addr` = `PROG_BASE[sel]` for START_CYCLES cycles via an internal down-counter, then RUN.
- RUN: `cycles` increments each cycle. `core_done` = 1 goes to FIN. Otherwise, when `cycles` reaches TIMEOUT, go to FAULT.
- RUN, simultaneous `core_done` and timeout: FIN wins.
- FIN: `run_done` = 1, `last_pc` ← `core_pc`, then IDLE.
- FAULT: `timeout` = 1, `last_pc` ← `core_pc`, `core_reset` = 1 for this cycle, then IDLE.
- `core_done` is ignored outside RUN. The core asserts `done` by PC threshold and may be high stale during RST/START.
- `req` is ignored while `busy`. There is no queueing.
- `boot_addr` = 0 outside START.
- `cycles` counts RUN cycles including the cycle in which `core_done` is seen. It never wraps because TIMEOUT bounds it.

## Timing
- All outputs are registered or decoded from the registered state only. There is no combinational path from inputs to outputs.
- Reset: state IDLE; every output 0, including `cycles` and `last_pc`.
- Reset mid-run: next cycle is IDLE with all outputs 0. No `run_done` or `timeout` pulse is emitted.
- `req` accepted at edge k: RST during cycle k+1, START during k+2..k+1+START_CYCLES, RUN from k+2+START_CYCLES.
- `core_done` high in RUN cycle m: FIN in cycle m+1 (`run_done` pulse), IDLE in m+2. `busy` drops in m+2.
- A new `req` can be accepted in the first IDLE cycle after FIN or FAULT.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum `run_state_t`
  - `PROG_BASE` constants: 10'd0, 10'd25, 10'd451
  - `PROG_CNT` = 3
- One sub-module, `run_cycle_counter`: CW-bit counter with synchronous clear, enable, and `hit` compare against TIMEOUT.
- The FSM and START down-counter live in the top of this block.

## Test plan
- Reset, then `req`, `prog_sel`=0, core model asserts `core_done` on 20th RUN cycle → `core_reset` one cycle, `core_start` exactly 2 cycles with `boot_addr`=0, `run_done` pulse, `cycles`=20, `busy` low 2 cycles after done.
- `prog_sel`=2, done after 349 RUN cycles → `boot_addr`=451 during START, `cycles`=349, `last_pc` = model PC.
- Core never asserts done, TIMEOUT=4096 → `timeout` pulse after 4096 RUN cycles, `cycles`=4096, `core_reset` high in FAULT cycle, no `run_done`.
- `req` with `prog_sel`=3 → single `bad_sel` pulse, `busy` stays 0; `req` pulsed during RUN → ignored, `cycles` unaffected.
- `core_done` held high through RST/START (stale) → not taken; done on RUN cycle 1 → `cycles`=1. Done on the same cycle as timeout → `run_done`, not `timeout`.
- `reset` asserted in RUN at `cycles`=50 → next cycle all outputs 0, state IDLE, no pulses; fresh `req` then runs normally.
